vga_timing_generator: RTL and testbench
=======================================

Name: vga_timing_generator

Overview:
- Produces the raster position counters (H_counter, V_counter) consumed by text_controller, plus HSYNC, VSYNC and video-enable for the VGA DAC/connector.
- Default timing is SVGA 800x600: 1056 clocks per line, 628 lines per frame, advancing one pixel per CLK.
- Sits between the board clock and every pixel-generating block, so all display logic sees one aligned, registered position.

Parameters:
H_VISIBLE, 800, visible pixels per line
H_FRONT, 40, horizontal front porch (pixels)
H_SYNC, 128, horizontal sync width (pixels)
H_BACK, 88, horizontal back porch (pixels); H_TOTAL = sum = 1056, must be <= 2048
V_VISIBLE, 600, visible lines per frame
V_FRONT, 1, vertical front porch (lines)
V_SYNC, 4, vertical sync width (lines)
V_BACK, 23, vertical back porch (lines); V_TOTAL = sum = 628, must be <= 1024
HS_POL, 1, HSYNC active level
VS_POL, 1, VSYNC active level
PIX_DIV, 1, CLK cycles per pixel (>= 1)

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous reset, active-high
H_counter  output  11  current pixel column, 0..H_TOTAL-1
V_counter  output  10  current line, 0..V_TOTAL-1
HSYNC  output  1  horizontal sync at HS_POL when active
VSYNC  output  1  vertical sync at VS_POL when active
video_on  output  1  1 when H_counter < H_VISIBLE and V_counter < V_VISIBLE
pix_stb  output  1  1-CLK pulse: new counter values present this cycle
line_start  output  1  1-CLK pulse: H_counter just became 0
frame_start  output  1  1-CLK pulse: counters just became (0,0)

Behaviour:
- All outputs are registered and change only on a CLK rising edge or on RST assertion.
- Every output corresponds to the counter values present in the same cycle, with zero skew between them.

Reset (asynchronous, immediate, no clock needed):
- H_counter = H_TOTAL-1 (1055), V_counter = V_TOTAL-1 (627).
- HSYNC = !HS_POL, VSYNC = !VS_POL.
- video_on = 0, pix_stb = 0, line_start = 0, frame_start = 0.
- Prescaler = 0.

Prescaler:
- Counts 0..PIX_DIV-1 and wraps; advance is taken on the edge where prescaler == PIX_DIV-1.
- With PIX_DIV=1, every edge advances.
- pix_stb = 1 for the CLK following each advance edge, else 0. With PIX_DIV=1, pix_stb is constant 1 after the first post-reset edge.

Advance rule:
- If H == H_TOTAL-1: H <= 0. Then if V == V_TOTAL-1, V <= 0; else V <= V+1.
- Otherwise H <= H+1 and V is unchanged.
- First advance after reset release therefore yields (0,0) with frame_start = 1 and line_start = 1.

Decode of the new counter values, registered on the same edge:
- HSYNC active when H_VISIBLE+H_FRONT <= H < H_VISIBLE+H_FRONT+H_SYNC (840..967).
- VSYNC active when V_VISIBLE+V_FRONT <= V < V_VISIBLE+V_FRONT+V_SYNC (601..604), for whole lines, independent of H.
- video_on per port definition.
- line_start = (new H == 0) on advance edges only.
- frame_start = (new H == 0 and new V == 0) on advance edges only.
- Pulses are 0 on non-advance edges.

Boundary conditions:
- Comparisons are unsigned at full counter width; no counter ever exceeds TOTAL-1.
- Reset asserted mid-frame: all outputs jump to reset values immediately and the prescaler clears. After release, the first advance occurs on the PIX_DIV-th rising edge.
- Reset released coincident with a clock edge: that edge does not advance.

Timing:
- Frame = H_TOTAL*V_TOTAL*PIX_DIV CLK cycles (663168 at defaults).

Test Plan:
1. Defaults, release RST -> first edge: H=0, V=0, video_on=1, frame_start=1, line_start=1, pix_stb=1, HSYNC=0, VSYNC=0; second edge: H=1, all pulses 0.
2. Run to H=799 then H=800 -> video_on goes 1 to 0 in the same cycle H reads 800; H=1055 -> next edge gives H=0, V=1, line_start=1, video_on=1.
3. HSYNC: 0 at H=839, 1 at H=840 through H=967, 0 at H=968; check with HS_POL=0 that levels invert.
4. Full frame -> VSYNC=1 exactly for V=601..604; video_on=0 for all V>=600; (1055,627) wraps to (0,0) with frame_start=1; consecutive frame_start pulses exactly 663168 cycles apart.
5. PIX_DIV=2 -> counters advance every second edge; pix_stb toggles 1,0,1,0; line period 2112 cycles.
6. Assert RST asynchronously (between edges) at H=500, V=300 -> H=1055, V=627, video_on=0, syncs inactive before the next edge; after release, sequence restarts as in scenario 1.

Source files
------------

// File: rtl/vga_timing_generator.sv
// Raster timing: registered H/V position, sync, blanking and strobes, all from the same edge.
// One-cycle registered latency from the advance edge; no backpressure, free-running once reset releases.
module vga_timing_generator #(
   parameter int H_VISIBLE = 800,
   parameter int H_FRONT   = 40,
   parameter int H_SYNC    = 128,
   parameter int H_BACK    = 88,
   parameter int V_VISIBLE = 600,
   parameter int V_FRONT   = 1,
   parameter int V_SYNC    = 4,
   parameter int V_BACK    = 23,
   parameter int HS_POL    = 1,
   parameter int VS_POL    = 1,
   parameter int PIX_DIV   = 1
) (
   input  logic        CLK,
   input  logic        RST,
   output logic [10:0] H_counter,
   output logic [9:0]  V_counter,
   output logic        HSYNC,
   output logic        VSYNC,
   output logic        video_on,
   output logic        pix_stb,
   output logic        line_start,
   output logic        frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int PW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
   localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0]  VS_BEG = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0]  VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [PW-1:0] PRE_LAST = PW'(PIX_DIV - 1);
   localparam logic HS_ON = (HS_POL != 0);
   localparam logic VS_ON = (VS_POL != 0);

   logic [PW-1:0] presc;
   logic          adv;
   logic [10:0]   h_nxt;
   logic [9:0]    v_nxt;

   // Decodes below use the next position so every output lines up with the counters it ships with.
   always_comb begin
      adv   = (presc == PRE_LAST);
      h_nxt = H_counter + 11'd1;
      v_nxt = V_counter;
      if (H_counter == H_LAST) begin
         h_nxt = '0;
         v_nxt = (V_counter == V_LAST) ? '0 : V_counter + 10'd1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         presc       <= '0;
         H_counter   <= H_LAST;
         V_counter   <= V_LAST;
         HSYNC       <= ~HS_ON;
         VSYNC       <= ~VS_ON;
         video_on    <= 1'b0;
         pix_stb     <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         presc       <= adv ? '0 : presc + PW'(1);
         pix_stb     <= adv;
         line_start  <= adv && (h_nxt == '0);
         frame_start <= adv && (h_nxt == '0) && (v_nxt == '0);
         if (adv) begin
            H_counter <= h_nxt;
            V_counter <= v_nxt;
            HSYNC     <= (h_nxt >= HS_BEG && h_nxt < HS_END) ? HS_ON : ~HS_ON;
            VSYNC     <= (v_nxt >= VS_BEG && v_nxt < VS_END) ? VS_ON : ~VS_ON;
            video_on  <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: four parameterisations share clock and reset and are compared
// against an arithmetic model of raster position derived from the count of edges since reset release.
module tb_vga_timing_generator;

   typedef struct packed {
      logic [10:0] h;
      logic [9:0]  v;
      logic        hs;
      logic        vs;
      logic        von;
      logic        stb;
      logic        ls;
      logic        fs;
   } out_t;

   localparam int HV[4] = '{800, 800, 8, 8};
   localparam int HF[4] = '{40, 40, 2, 2};
   localparam int HS[4] = '{128, 128, 3, 3};
   localparam int HB[4] = '{88, 88, 3, 3};
   localparam int VV[4] = '{600, 600, 6, 6};
   localparam int VF[4] = '{1, 1, 1, 1};
   localparam int VS[4] = '{4, 4, 2, 2};
   localparam int VB[4] = '{23, 23, 3, 3};
   localparam int HP[4] = '{1, 0, 1, 0};
   localparam int VP[4] = '{1, 0, 1, 1};
   localparam int DV[4] = '{1, 2, 1, 3};

   logic        CLK;
   logic        RST;
   logic [10:0] hc  [4];
   logic [9:0]  vc  [4];
   logic        hsy [4];
   logic        vsy [4];
   logic        von [4];
   logic        stb [4];
   logic        ls  [4];
   logic        fs  [4];

   int e = 0;
   int vectors = 0;
   int miscompares = 0;

   vga_timing_generator u0 (
      .CLK(CLK), .RST(RST), .H_counter(hc[0]), .V_counter(vc[0]), .HSYNC(hsy[0]), .VSYNC(vsy[0]),
      .video_on(von[0]), .pix_stb(stb[0]), .line_start(ls[0]), .frame_start(fs[0]));

   vga_timing_generator #(.HS_POL(0), .VS_POL(0), .PIX_DIV(2)) u1 (
      .CLK(CLK), .RST(RST), .H_counter(hc[1]), .V_counter(vc[1]), .HSYNC(hsy[1]), .VSYNC(vsy[1]),
      .video_on(von[1]), .pix_stb(stb[1]), .line_start(ls[1]), .frame_start(fs[1]));

   vga_timing_generator #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3), .V_VISIBLE(6),
      .V_FRONT(1), .V_SYNC(2), .V_BACK(3), .HS_POL(1), .VS_POL(1), .PIX_DIV(1)) u2 (
      .CLK(CLK), .RST(RST), .H_counter(hc[2]), .V_counter(vc[2]), .HSYNC(hsy[2]), .VSYNC(vsy[2]),
      .video_on(von[2]), .pix_stb(stb[2]), .line_start(ls[2]), .frame_start(fs[2]));

   vga_timing_generator #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3), .V_VISIBLE(6),
      .V_FRONT(1), .V_SYNC(2), .V_BACK(3), .HS_POL(0), .VS_POL(1), .PIX_DIV(3)) u3 (
      .CLK(CLK), .RST(RST), .H_counter(hc[3]), .V_counter(vc[3]), .HSYNC(hsy[3]), .VSYNC(vsy[3]),
      .video_on(von[3]), .pix_stb(stb[3]), .line_start(ls[3]), .frame_start(fs[3]));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Rising edges seen with reset low since the last release.
   always @(posedge CLK) begin
      if (RST) e <= 0;
      else     e <= e + 1;
   end

   // Position after n advances is simply index (n-1) of a linear scan of the H_TOTAL x V_TOTAL raster.
   function automatic out_t model(int k, int edges);
      out_t r;
      int ht, vt, n, p, h, v;
      logic hact, vact;
      ht = HV[k] + HF[k] + HS[k] + HB[k];
      vt = VV[k] + VF[k] + VS[k] + VB[k];
      n  = edges / DV[k];
      if (n == 0) begin
         r.h = 11'(ht - 1);
         r.v = 10'(vt - 1);
         r.hs = (HP[k] != 0) ? 1'b0 : 1'b1;
         r.vs = (VP[k] != 0) ? 1'b0 : 1'b1;
         r.von = 1'b0;
         r.stb = 1'b0;
         r.ls = 1'b0;
         r.fs = 1'b0;
      end else begin
         p = (n - 1) % (ht * vt);
         h = p % ht;
         v = p / ht;
         hact = (h >= HV[k] + HF[k]) && (h < HV[k] + HF[k] + HS[k]);
         vact = (v >= VV[k] + VF[k]) && (v < VV[k] + VF[k] + VS[k]);
         r.h = 11'(h);
         r.v = 10'(v);
         r.hs = hact ? (HP[k] != 0) : (HP[k] == 0);
         r.vs = vact ? (VP[k] != 0) : (VP[k] == 0);
         r.von = (h < HV[k]) && (v < VV[k]);
         r.stb = (edges % DV[k] == 0);
         r.ls = r.stb && (h == 0);
         r.fs = r.ls && (v == 0);
      end
      return r;
   endfunction

   function automatic out_t dut(int k);
      return {hc[k], vc[k], hsy[k], vsy[k], von[k], stb[k], ls[k], fs[k]};
   endfunction

   task automatic test_reset();
      out_t got, exp;
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      for (int k = 0; k < 4; k++) begin
         got = dut(k);
         exp = model(k, 0);
         vectors++;
         if (got !== exp) begin
            $display("FAIL reset k=%0d got=%h exp=%h", k, got, exp);
            miscompares++;
         end
      end
      vectors++;
      if ({hc[0], vc[0]} !== {11'd1055, 10'd627}) begin
         $display("FAIL reset_pos got=%0d,%0d exp=1055,627", hc[0], vc[0]);
         miscompares++;
      end
      RST = 1'b0;
   endtask

   task automatic test_first_advance();
      out_t got, exp;
      @(negedge CLK);
      got = dut(0); exp = {11'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      vectors++;
      if (got !== exp) begin $display("FAIL first_edge_d0 got=%h exp=%h", got, exp); miscompares++; end
      got = dut(1); exp = {11'd1055, 10'd627, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vectors++;
      if (got !== exp) begin $display("FAIL first_edge_d1 got=%h exp=%h", got, exp); miscompares++; end
      @(negedge CLK);
      got = dut(0); exp = {11'd1, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vectors++;
      if (got !== exp) begin $display("FAIL second_edge_d0 got=%h exp=%h", got, exp); miscompares++; end
      got = dut(1); exp = {11'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vectors++;
      if (got !== exp) begin $display("FAIL second_edge_d1 got=%h exp=%h", got, exp); miscompares++; end
      @(negedge CLK);
      got = dut(1); exp = {11'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vectors++;
      if (got !== exp) begin $display("FAIL third_edge_d1 got=%h exp=%h", got, exp); miscompares++; end
      @(negedge CLK);
      got = dut(1); exp = {11'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vectors++;
      if (got !== exp) begin $display("FAIL fourth_edge_d1 got=%h exp=%h", got, exp); miscompares++; end
   endtask

   task automatic test_h_boundaries();
      int te[12] = '{800, 801, 840, 841, 968, 969, 1056, 1057, 1680, 1682, 1936, 1938};
      int tk[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
      int th[12] = '{799, 800, 839, 840, 967, 968, 1055, 0, 839, 840, 967, 968};
      int tv[12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
      logic ths[12] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 1};
      logic tvo[12] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
      logic tls[12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
      logic [23:0] got, exp;
      int guard;
      for (int i = 0; i < 12; i++) begin
         guard = 0;
         while (e < te[i] && guard < 5000) begin
            @(negedge CLK);
            guard++;
         end
         got = {hc[tk[i]], vc[tk[i]], hsy[tk[i]], von[tk[i]], ls[tk[i]]};
         exp = {11'(th[i]), 10'(tv[i]), ths[i], tvo[i], tls[i]};
         vectors++;
         if (got !== exp) begin
            $display("FAIL h_boundary e=%0d k=%0d got=%h exp=%h", te[i], tk[i], got, exp);
            miscompares++;
         end
      end
   endtask

   task automatic test_model_run(int ncyc);
      out_t got, exp;
      repeat (ncyc) begin
         @(negedge CLK);
         for (int k = 0; k < 4; k++) begin
            got = dut(k);
            exp = model(k, e);
            vectors++;
            if (got !== exp) begin
               $display("FAIL model_run k=%0d e=%0d got=%h exp=%h", k, e, got, exp);
               miscompares++;
            end
         end
      end
   endtask

   task automatic test_periods();
      int last[4] = '{-1, -1, -1, -1};
      int want[4] = '{1056, 2112, 192, 576};
      int seen[4] = '{0, 0, 0, 0};
      logic pulse;
      repeat (4600) begin
         @(negedge CLK);
         for (int k = 0; k < 4; k++) begin
            pulse = (k < 2) ? ls[k] : fs[k];
            if (pulse) begin
               if (last[k] >= 0) begin
                  vectors++;
                  seen[k]++;
                  if (e - last[k] != want[k]) begin
                     $display("FAIL period k=%0d got=%0d exp=%0d", k, e - last[k], want[k]);
                     miscompares++;
                  end
               end
               last[k] = e;
            end
         end
      end
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (seen[k] < 1) begin
            $display("FAIL period_seen k=%0d got=%0d exp>=1", k, seen[k]);
            miscompares++;
         end
      end
   endtask

   task automatic test_async_reset();
      out_t got, exp;
      for (int r = 0; r < 3; r++) begin
         test_model_run($urandom_range(50, 2000));
         #2 RST = 1'b1;
         #1;
         for (int k = 0; k < 4; k++) begin
            got = dut(k);
            exp = model(k, 0);
            vectors++;
            if (got !== exp) begin
               $display("FAIL async_reset k=%0d got=%h exp=%h", k, got, exp);
               miscompares++;
            end
         end
         repeat ($urandom_range(1, 4)) @(negedge CLK);
         for (int k = 0; k < 4; k++) begin
            got = dut(k);
            exp = model(k, 0);
            vectors++;
            if (got !== exp) begin
               $display("FAIL reset_hold k=%0d got=%h exp=%h", k, got, exp);
               miscompares++;
            end
         end
         RST = 1'b0;
         test_model_run(700);
      end
   endtask

   initial begin
      RST = 1'b1;
      test_reset();
      test_first_advance();
      test_h_boundaries();
      test_model_run(6000);
      test_periods();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
